// File: rtl/spi_master_if.sv
// Pin and handshake bundle for spi_master.
// master: the view seen by spi_master itself.
// slave:  the view seen by the command logic and the SPI pins.
interface spi_master_if;
  localparam int unsigned FRAME_W   = 24;
  localparam int unsigned CMD_W     = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PAYLOAD_W = 8;

  // Command-side handshake
  logic                 i_start;
  logic [CMD_W-1:0]     i_cmd;
  logic [ADDR_W-1:0]    i_addr;
  logic [PAYLOAD_W-1:0] i_payload;
  logic                 o_busy;
  logic                 o_done;
  logic [FRAME_W-1:0]   o_rx_frame;

  // SPI pins
  logic                 sclk;
  logic                 cs;
  logic                 mosi;
  logic                 miso;

  modport master (
    input  i_start, i_cmd, i_addr, i_payload, miso,
    output o_busy, o_done, o_rx_frame, sclk, cs, mosi
  );

  modport slave (
    output i_start, i_cmd, i_addr, i_payload, miso,
    input  o_busy, o_done, o_rx_frame, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode 0 master: one 24-bit frame {cmd, addr, payload} out on MOSI,
// optional 24-bit reply captured from MISO.
// Build option: define SPI_MASTER_RX_EN to include MISO capture; otherwise
// miso is ignored and o_rx_frame is tied to 0 (TX timing is identical).
// Parameter legal ranges: HALF_PERIOD 6..255, CS_SETUP 2..255,
// CS_HOLD 4..255, CS_IDLE 2..255.
module spi_master #(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 8,
  parameter int unsigned CS_IDLE     = 8
) (
  input  logic          sysclk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 5;

  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  // Terminal counts: a phase of N cycles ends on the edge where cnt_q == N-1
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] LAST_FALL  = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  // Bits still to send; bit 23 goes out on acceptance so only 23 are kept
  logic [FRAME_W-2:0]   tx_q, tx_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_q, cs_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef SPI_MASTER_RX_EN
  // 23 samples come from SCLK rises; the 24th is taken straight into o_rx_frame
  logic [FRAME_W-2:0]   rx_q, rx_d;
  logic [FRAME_W-1:0]   rx_frame_q, rx_frame_d;
`endif

  // Next-state and output logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPI_MASTER_RX_EN
    rx_d       = rx_q;
    rx_frame_d = rx_frame_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          tx_d    = {bus.i_cmd[6:0], bus.i_addr, bus.i_payload};
          mosi_d  = bus.i_cmd[7];
          cs_d    = CS_ASSERT;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: launch next MOSI bit; zeros shift in behind the frame
            sclk_d = 1'b0;
            mosi_d = tx_q[FRAME_W-2];
            tx_d   = {tx_q[FRAME_W-3:0], 1'b0};
            bit_d  = bit_q + BIT_W'(1);
            if (bit_q == LAST_FALL) begin
              state_d = S_HOLD;
            end
          end else begin
            // Rising edge: rises 1..23 capture the reply bit launched on the previous fall
            sclk_d = 1'b1;
`ifdef SPI_MASTER_RX_EN
            rx_d   = {rx_q[FRAME_W-3:0], bus.miso};
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_d    = CS_DEASSERT;
          done_d  = 1'b1;
`ifdef SPI_MASTER_RX_EN
          rx_frame_d = {rx_q, bus.miso};
`endif
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= CS_DEASSERT;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_MASTER_RX_EN
  // Reply shift register and captured frame
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      rx_frame_q <= '0;
    end else begin
      rx_q       <= rx_d;
      rx_frame_q <= rx_frame_d;
    end
  end

  assign bus.o_rx_frame = rx_frame_q;
`else
  logic unused_miso_c;
  assign unused_miso_c  = bus.miso;
  assign bus.o_rx_frame = '0;
`endif

  assign bus.sclk   = sclk_q;
  assign bus.cs     = cs_q;
  assign bus.mosi   = mosi_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master at default timing parameters.
module tb_spi_master;

  localparam int unsigned T_DONE  = 388;  // E0 to CS deassert / o_done
  localparam int unsigned T_BUSY  = 396;  // E0 to o_busy low
  localparam int unsigned GAP_MIN = 9;    // CS_IDLE + 1

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  spi_master_if bus();

  spi_master #(
    .HALF_PERIOD (8),
    .CS_SETUP    (4),
    .CS_HOLD     (8),
    .CS_IDLE     (8)
  ) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [23:0] tx;
    logic [23:0] rx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] miso_word = 24'h0;
  bit          held_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reply the master should report: the full slave word, or 0 without RX capture
  function automatic logic [23:0] model_rx(input logic [23:0] w);
`ifdef SPI_MASTER_RX_EN
    return w;
`else
    return w & 24'h0;
`endif
  endfunction

  // Slave-side MISO: bit j of the word (MSB first) is launched after SCLK fall j
  initial begin : miso_model
    logic        pc, ps;
    logic [23:0] w;
    int          idx;
    pc = 1'b1; ps = 1'b0; w = '0; idx = 24;
    bus.miso = 1'b0;
    forever begin
      @(bus.cs or bus.sclk);
      if (pc && !bus.cs) begin
        w   = miso_word;
        idx = 0;
      end
      if (ps && !bus.sclk && !bus.cs && idx < 24) begin
        bus.miso = w[5'(23 - idx)];
        idx++;
      end
      pc = bus.cs;
      ps = bus.sclk;
    end
  end

  // Monitor: watches the pins each negedge, pops the scoreboard on o_done
  initial begin : monitor
    int          n, e0, rise_n, rises;
    logic [23:0] mw;
    logic        pc, ps, pb, pd;
    bit          have_end;
    exp_t        e;
    n = 0; e0 = 0; rise_n = 0; rises = 0; mw = '0;
    pc = 1'b1; ps = 1'b0; pb = 1'b0; pd = 1'b0; have_end = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (!rst_n) begin
        exp_q.delete();
        have_end = 1'b0;
        rises = 0;
        pc = 1'b1; ps = 1'b0; pb = 1'b0; pd = 1'b0;
        continue;
      end
      if (pc && !bus.cs) begin
        if (have_end) begin
          check("cs_gap_min", 32'((n - rise_n) >= int'(GAP_MIN)), 32'd1);
          if (held_chk) check("held_restart_gap", 32'(n - rise_n), 32'(GAP_MIN));
        end
        e0 = n; rises = 0; mw = '0; have_end = 1'b0;
      end
      if (!ps && bus.sclk && !bus.cs) begin
        rises++;
        mw = {mw[22:0], bus.mosi};
      end
      if (bus.o_done) begin
        check("done_width", 32'(pd), 32'd0);
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("mosi_frame", 32'(mw), 32'(e.tx));
          check("rx_frame", 32'(bus.o_rx_frame), 32'(e.rx));
          check("sclk_rises", 32'(rises), 32'd24);
          check("done_time", 32'(n - e0), 32'(T_DONE));
          check("cs_at_done", 32'(bus.cs), 32'd1);
        end
        have_end = 1'b1;
        rise_n = n;
      end
      if (pb && !bus.o_busy) check("busy_time", 32'(n - e0), 32'(T_BUSY));
      pc = bus.cs; ps = bus.sclk; pb = bus.o_busy; pd = bus.o_done;
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_cs"},    32'(bus.cs),         32'd1);
    check({tag, "_sclk"},  32'(bus.sclk),       32'd0);
    check({tag, "_mosi"},  32'(bus.mosi),       32'd0);
    check({tag, "_busy"},  32'(bus.o_busy),     32'd0);
    check({tag, "_done"},  32'(bus.o_done),     32'd0);
    check({tag, "_rx"},    32'(bus.o_rx_frame), 32'd0);
  endtask

  // Called at a negedge; returns once busy is low or the bound expires
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.o_busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic scramble();
    {bus.i_cmd, bus.i_addr, bus.i_payload} = 24'($urandom());
  endtask

  task automatic send(input logic [23:0] tx, input logic [23:0] mw, input bit poke);
    wait_idle("idle_timeout");
    {bus.i_cmd, bus.i_addr, bus.i_payload} = tx;
    miso_word   = mw;
    bus.i_start = 1'b1;
    exp_q.push_back({tx, model_rx(mw)});
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    scramble();
    if (poke) begin
      repeat (99) @(posedge clk);
      #1;
      bus.i_start = 1'b1;
      scramble();
      @(posedge clk); #1;
      bus.i_start = 1'b0;
    end
    @(negedge clk);
    wait_idle("frame_timeout");
  endtask

  initial begin : driver
    logic [23:0] ta, tb_w, ma, mb;
    int          r, k;
    logic        ps;

    bus.i_start = 1'b0;
    {bus.i_cmd, bus.i_addr, bus.i_payload} = '0;

    // Reset with random inputs
    #1;
    rst_n = 1'b0;
    bus.i_start = 1'($urandom());
    scramble();
    #1;
    reset_checks("rst_now");
    repeat (3) begin
      @(negedge clk);
      bus.i_start = 1'($urandom());
      scramble();
    end
    reset_checks("rst_held");
    bus.i_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write/readback frame
    send(24'h010280, 24'hA5C3F0, 1'b0);

    // Random frames; the first also gets a stray start at E0+100
    for (int i = 0; i < 6; i++) begin
      send(24'($urandom()), 24'($urandom()), i == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // i_start held high across two frames
    ta = 24'($urandom()); tb_w = 24'($urandom());
    ma = 24'($urandom()); mb = 24'($urandom());
    wait_idle("held_idle_timeout");
    held_chk = 1'b1;
    {bus.i_cmd, bus.i_addr, bus.i_payload} = ta;
    miso_word   = ma;
    bus.i_start = 1'b1;
    exp_q.push_back({ta, model_rx(ma)});
    @(posedge clk); #1;
    miso_word = mb;
    {bus.i_cmd, bus.i_addr, bus.i_payload} = tb_w;
    exp_q.push_back({tb_w, model_rx(mb)});
    @(negedge clk);
    wait_idle("held_first_timeout");
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    scramble();
    @(negedge clk);
    @(negedge clk);
    held_chk = 1'b0;
    wait_idle("held_second_timeout");

    // Reset after SCLK rise 10
    @(negedge clk);
    {bus.i_cmd, bus.i_addr, bus.i_payload} = 24'($urandom());
    miso_word   = 24'($urandom());
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    r = 0; k = 0; ps = 1'b0;
    while (r < 10 && k < 1000) begin
      @(negedge clk);
      if (!ps && bus.sclk) r++;
      ps = bus.sclk;
      k++;
    end
    check("rise10_reached", 32'(r), 32'd10);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 32'(bus.o_done), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_done", 32'(exp_q.size()), 32'd0);

    // Clean frame after the aborted one
    send(24'hFF00AA, 24'($urandom()), 1'b0);

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
